log_acc_sequencer: RTL

//  Sequences the log-to-linear accumulate datapath (LogNumberToLogNumberUnpacked + LogAdd) over vectors.

---
 rtl/log_acc_sequencer_pkg.sv | 48 ++++
 rtl/log_acc_sequencer_if.sv | 26 ++
 rtl/log_acc_sequencer_logadd.sv | 45 ++++
 rtl/log_acc_sequencer.sv | 90 +++++++++
 4 files changed

// File: rtl/log_acc_sequencer_pkg.sv
// rtl/log_acc_sequencer_pkg.sv - shared widths, state enum and log-number unpacking
package log_acc_sequencer_pkg;

   localparam int M                  = 3;
   localparam int F                  = 4;
   localparam int LOG_TO_LINEAR_BITS = 8;
   localparam int CNT_W              = 16;

   function automatic int acc_non_frac(input int m);
      return 1 + (2 ** (m - 1) - 1);
   endfunction

   function automatic int acc_frac(input int m, input int l2l);
      return l2l + 2 ** (m - 1);
   endfunction

   // Guard bits above the Kulisch integer part absorb carries of up to 2**CNT_W beats.
   function automatic int kulisch_width(input int non_frac, input int frac, input int guard);
      return non_frac + frac + guard;
   endfunction

   localparam int ACC_NON_FRAC = acc_non_frac(M);
   localparam int ACC_FRAC     = acc_frac(M, LOG_TO_LINEAR_BITS);
   localparam int KW           = kulisch_width(ACC_NON_FRAC, ACC_FRAC, CNT_W);
   localparam int LW           = M + F + 1;

   // Most negative exponent encodes zero, independent of sign.
   localparam logic [M+F-1:0] ZERO_EXP = {1'b1, {(M + F - 1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, HOLD} state_e;

   typedef struct packed {
      logic                sign;
      logic                zero;
      logic signed [M-1:0] int_part;
      logic [F-1:0]        frac;
   } log_unpacked_t;

   function automatic log_unpacked_t unpack_log(input logic [LW-1:0] packed_log);
      log_unpacked_t u;
      u.sign     = packed_log[LW-1];
      u.zero     = (packed_log[M+F-1:0] == ZERO_EXP);
      u.int_part = packed_log[M+F-1:F];
      u.frac     = packed_log[F-1:0];
      return u;
   endfunction

endpackage

// File: rtl/log_acc_sequencer_if.sv
// rtl/log_acc_sequencer_if.sv - input beat stream, result port and control signals
interface log_acc_sequencer_if;
   import log_acc_sequencer_pkg::*;

   logic             clear;
   logic             in_valid;
   logic             in_ready;
   logic [LW-1:0]    in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [KW-1:0]    out_acc;
   logic [CNT_W-1:0] out_count;
   logic             busy;

   modport master (
      output clear, in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_count, busy
   );

   modport slave (
      input  clear, in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_count, busy
   );

endinterface

// File: rtl/log_acc_sequencer_logadd.sv
// rtl/log_acc_sequencer_logadd.sv - converts one unpacked log number to linear and adds it exactly into the Kulisch sum
module log_acc_sequencer_logadd
   import log_acc_sequencer_pkg::*;
(
   input  log_unpacked_t log_i,
   input  logic [KW-1:0] acc_i,
   output logic [KW-1:0] acc_o
);

   localparam logic [M:0] SHIFT_BIAS = (M + 1)'(ACC_FRAC - LOG_TO_LINEAR_BITS);

   logic [LOG_TO_LINEAR_BITS:0] mant;
   logic [M:0]                  shift;
   logic [KW-1:0]               lin;

   // round(2**(frac/16) * 256): mantissa with LOG_TO_LINEAR_BITS fraction bits
   always_comb begin
      mant = 9'd256;
      case (log_i.frac)
         4'd0:  mant = 9'd256;
         4'd1:  mant = 9'd267;
         4'd2:  mant = 9'd279;
         4'd3:  mant = 9'd292;
         4'd4:  mant = 9'd304;
         4'd5:  mant = 9'd318;
         4'd6:  mant = 9'd332;
         4'd7:  mant = 9'd347;
         4'd8:  mant = 9'd362;
         4'd9:  mant = 9'd378;
         4'd10: mant = 9'd395;
         4'd11: mant = 9'd412;
         4'd12: mant = 9'd431;
         4'd13: mant = 9'd450;
         4'd14: mant = 9'd470;
         4'd15: mant = 9'd490;
         default: mant = 9'd256;
      endcase
   end

   // Biased integer part is never negative, so the shift is always left and lossless.
   assign shift = {log_i.int_part[M-1], log_i.int_part} + SHIFT_BIAS;
   assign lin   = KW'(mant) << shift;
   assign acc_o = log_i.zero ? acc_i : (log_i.sign ? acc_i - lin : acc_i + lin);

endmodule

// File: rtl/log_acc_sequencer.sv
// rtl/log_acc_sequencer.sv - accepts log-number vectors and emits one exact Kulisch sum and beat count per vector
module log_acc_sequencer
   import log_acc_sequencer_pkg::*;
(
   input  logic               clock,
   input  logic               resetN,
   log_acc_sequencer_if.slave bus
);

   state_e           state_q, state_d;
   log_unpacked_t    s1_log_q, s1_log_d;
   logic             s1_valid_q, s1_valid_d;
   logic [KW-1:0]    acc_q, acc_d, acc_sum;
   logic [CNT_W-1:0] count_q, count_d;
   logic             out_valid_q, out_valid_d;
   logic             in_ready, accept, handshake;

   assign in_ready  = !bus.clear && (state_q == IDLE || state_q == RUN);
   assign accept    = bus.in_valid && in_ready;
   assign handshake = out_valid_q && bus.out_ready;

   log_acc_sequencer_logadd u_logadd (
      .log_i (s1_log_q),
      .acc_i (acc_q),
      .acc_o (acc_sum)
   );

   always_comb begin
      state_d     = state_q;
      s1_log_d    = s1_log_q;
      s1_valid_d  = accept;
      acc_d       = acc_q;
      count_d     = count_q;
      out_valid_d = 1'b0;

      if (accept) s1_log_d = unpack_log(bus.in_data);
      if (s1_valid_q) begin
         acc_d   = acc_sum;
         count_d = (count_q == '1) ? count_q : count_q + 1'b1;
      end

      case (state_q)
         IDLE, RUN: if (accept) state_d = bus.in_last ? FLUSH : RUN;
         FLUSH:     state_d = HOLD;
         HOLD: begin
            // First HOLD cycle raises out_valid; the handshake drops it and rearms.
            out_valid_d = !handshake;
            if (handshake) begin
               state_d = IDLE;
               acc_d   = '0;
               count_d = '0;
            end
         end
         default:   state_d = IDLE;
      endcase

      if (bus.clear) begin
         state_d     = IDLE;
         s1_valid_d  = 1'b0;
         acc_d       = '0;
         count_d     = '0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q     <= IDLE;
         s1_log_q    <= '0;
         s1_valid_q  <= 1'b0;
         acc_q       <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s1_log_q    <= s1_log_d;
         s1_valid_q  <= s1_valid_d;
         acc_q       <= acc_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = acc_q;
   assign bus.out_count = count_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
